ebus_arbiter: RTL
=================

Name: ebus_arbiter

Overview:
Owns the shared EBUS inside the EBOX. It grants the bus to one of two requesters (EBOX microcode via CON, or PI for channel/interrupt cycles), sequences each transfer's demand/acknowledge handshake with a timeout, and merges the per-slice driver outputs (APR, CON, CRA, CTL, EDP, IR, PI) onto the bus with parity and contention checking. It sits between CON/PI and the EBUS driver slices, replacing ad hoc grant logic.

Parameters:
NDRV, 7, number of EBUS driver slices merged
DW, 36, EBUS data width
TIMEOUT, 15, cycles DEMAND may wait for xferAck before abort (1..255)

Ports:
eboxClk  in  1  EBOX clock; all state on rising edge
eboxReset  in  1  asynchronous, active-high reset
eboxReq  in  1  CON requests bus (level; drop = release)
piReq  in  1  PI requests bus (level; drop = release)
eboxGrant  out  1  bus owned by EBOX
piGrant  out  1  bus owned by PI
xferStart  in  1  owner pulses to begin a transfer (ignored unless a grant is held and state is OWNED)
xferFunc  in  3  EBUS function code, sampled with xferStart
xferAck  in  1  addressed device completed transfer
ebusDemand  out  1  demand strobe to devices
ebusFunc  out  3  registered function code while ebusDemand
xferDone  out  1  one-cycle pulse, transfer acknowledged
xferTimeout  out  1  one-cycle pulse, transfer aborted
drvEn  in  NDRV  per-slice "driving" flags
drvData  in  NDRV*DW  per-slice data, slice i at bits [i*DW +: DW]
ebusData  out  DW  merged bus data
ebusParity  out  1  odd parity over ebusData
contention  out  1  more than one drvEn set (registered, sticky until reset or eboxRel)
eboxRel  in  1  clears contention flag

Behaviour:
- Reset (async): state IDLE; eboxGrant, piGrant, ebusDemand, xferDone, xferTimeout, contention = 0; ebusFunc = 0; timeout counter = 0.
- States: IDLE, OWNED, DEMAND, RELEASE.
- IDLE: if piReq -> piGrant=1, OWNED (PI has fixed priority on tie). Else if eboxReq -> eboxGrant=1, OWNED. Grant appears the cycle after the request is sampled (1-cycle latency).
- OWNED: if owner's req drops -> RELEASE (grant deasserts next edge). Else if xferStart -> latch xferFunc into ebusFunc, ebusDemand=1, counter=0, DEMAND. Non-owner requests are held off; no preemption.
- DEMAND: counter increments each cycle. If xferAck -> ebusDemand=0, xferDone pulse, OWNED. Else if counter == TIMEOUT-1 -> ebusDemand=0, xferTimeout pulse, OWNED. xferAck and timeout in the same cycle: xferDone wins, no timeout pulse. Owner req dropping during DEMAND is ignored until the transfer finishes; then OWNED sees the dropped req and releases.
- RELEASE: both grants 0 for exactly one cycle (bus turnaround), then IDLE. Requests pending then are arbitrated in IDLE next cycle.
- Exactly one of eboxGrant/piGrant is high at a time; never both.
- xferStart while in DEMAND/RELEASE/IDLE: ignored, no pulse.
- Data merge (combinational): ebusData = bitwise OR of drvData slices whose drvEn is set; 0 if none. ebusParity = ~^ebusData (odd parity: total ones including parity bit odd).
- contention: set on any edge where popcount(drvEn) >= 2; cleared by eboxRel (eboxRel wins over a simultaneous set only if popcount < 2 that cycle; set has priority).
- Reset mid-transfer: demand and grants drop immediately (async); no xferDone/xferTimeout generated.

Test Plan:
- Reset then eboxReq=1 -> eboxGrant=1 on 2nd edge, piGrant=0; drop eboxReq -> grant 0 next edge, one RELEASE cycle, IDLE.
- eboxReq and piReq rise same cycle -> piGrant=1; PI drops req -> one dead cycle -> eboxGrant=1.
- Owner pulses xferStart, xferFunc=3'b101, xferAck after 4 cycles -> ebusDemand high 4 cycles, ebusFunc=5, xferDone single pulse, no timeout.
- xferStart with no ack, TIMEOUT=15 -> ebusDemand high exactly 15 cycles, xferTimeout pulse, state OWNED; ack on the 15th cycle -> xferDone only.
- drvEn=0000100, EDP slice = 36'o123456701234 -> ebusData equals it, ebusParity correct odd; drvEn=0000101 -> OR of slices, contention=1 until eboxRel.
- Assert eboxReset during DEMAND -> ebusDemand, grants 0 asynchronously; no done/timeout pulse after release.

Source files
------------

// File: rtl/ebus_arbiter.sv
// EBUS owner arbitration between CON and PI, demand/acknowledge sequencing with timeout,
// and merging of the per-slice driver outputs with parity and contention detection.
module ebus_arbiter #(
   parameter int unsigned NDRV    = 7,
   parameter int unsigned DW      = 36,
   parameter int unsigned TIMEOUT = 15
) (
   input  logic                eboxClk,
   input  logic                eboxReset,
   input  logic                eboxReq,
   input  logic                piReq,
   output logic                eboxGrant,
   output logic                piGrant,
   input  logic                xferStart,
   input  logic [2:0]          xferFunc,
   input  logic                xferAck,
   output logic                ebusDemand,
   output logic [2:0]          ebusFunc,
   output logic                xferDone,
   output logic                xferTimeout,
   input  logic [NDRV-1:0]     drvEn,
   input  logic [NDRV*DW-1:0]  drvData,
   output logic [DW-1:0]       ebusData,
   output logic                ebusParity,
   output logic                contention,
   input  logic                eboxRel
);

   typedef enum logic [1:0] {StIdle, StOwned, StDemand, StRelease} state_t;

   localparam logic [7:0]      LP_TMO_LAST = 8'(TIMEOUT - 1);
   localparam logic [NDRV-1:0] LP_ONE      = NDRV'(1);

   state_t          r_state;
   logic            r_ebox_grant;
   logic            r_pi_grant;
   logic            r_demand;
   logic [2:0]      r_func;
   logic            r_done;
   logic            r_timeout;
   logic [7:0]      r_cnt;
   logic            r_contention;

   logic            w_owner_req;
   logic            w_multi;
   logic [DW-1:0]   w_data;

   assign w_owner_req = (r_ebox_grant & eboxReq) | (r_pi_grant & piReq);

   // Clearing the lowest set bit leaves something only when two or more drivers are on.
   assign w_multi = (drvEn & (drvEn - LP_ONE)) != '0;

   always_comb begin
      w_data = '0;
      for (int i = 0; i < int'(NDRV); i++) begin
         if (drvEn[i]) begin
            w_data = w_data | drvData[i*DW +: DW];
         end
      end
   end

   always_ff @(posedge eboxClk or posedge eboxReset) begin
      if (eboxReset) begin
         r_state      <= StIdle;
         r_ebox_grant <= 1'b0;
         r_pi_grant   <= 1'b0;
         r_demand     <= 1'b0;
         r_func       <= 3'b000;
         r_done       <= 1'b0;
         r_timeout    <= 1'b0;
         r_cnt        <= 8'd0;
      end else begin
         r_done    <= 1'b0;
         r_timeout <= 1'b0;
         case (r_state)
            StIdle: begin
               if (piReq) begin
                  r_pi_grant <= 1'b1;
                  r_state    <= StOwned;
               end else if (eboxReq) begin
                  r_ebox_grant <= 1'b1;
                  r_state      <= StOwned;
               end
            end
            StOwned: begin
               if (!w_owner_req) begin
                  r_ebox_grant <= 1'b0;
                  r_pi_grant   <= 1'b0;
                  r_state      <= StRelease;
               end else if (xferStart) begin
                  r_func   <= xferFunc;
                  r_demand <= 1'b1;
                  r_cnt    <= 8'd0;
                  r_state  <= StDemand;
               end
            end
            StDemand: begin
               // An acknowledge in the final cycle still counts as a completed transfer.
               if (xferAck) begin
                  r_demand <= 1'b0;
                  r_done   <= 1'b1;
                  r_state  <= StOwned;
               end else if (r_cnt == LP_TMO_LAST) begin
                  r_demand  <= 1'b0;
                  r_timeout <= 1'b1;
                  r_state   <= StOwned;
               end else begin
                  r_cnt <= r_cnt + 8'd1;
               end
            end
            StRelease: begin
               r_state <= StIdle;
            end
            default: begin
               r_state <= StIdle;
            end
         endcase
      end
   end

   always_ff @(posedge eboxClk or posedge eboxReset) begin
      if (eboxReset) begin
         r_contention <= 1'b0;
      end else if (w_multi) begin
         r_contention <= 1'b1;
      end else if (eboxRel) begin
         r_contention <= 1'b0;
      end
   end

   assign eboxGrant   = r_ebox_grant;
   assign piGrant     = r_pi_grant;
   assign ebusDemand  = r_demand;
   assign ebusFunc    = r_func;
   assign xferDone    = r_done;
   assign xferTimeout = r_timeout;
   assign contention  = r_contention;
   assign ebusData    = w_data;
   assign ebusParity  = ~^w_data;

endmodule
